sector_read_arbiter: RTL and testbench

Shares one storage back-end sector reader between two requesters: port 0 is the IDE device read path, port 1 is a maintenance/debug path. Each requester issues a one-cycle read pulse with an LBA and sees the same busy/done handshake the IDE device already expects. The block latches requests, grants the back end round-robin, routes the 512-byte stream to the granted requester, and enforces a per-byte watchdog with abort and drain.

---
 rtl/sector_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sector_read_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sector_read_arbiter.sv
// Two-port sector read arbiter: latches one-cycle read requests, grants the
// shared back-end reader round-robin, routes the byte stream to the granted
// port and aborts/drains the back end when a per-byte watchdog expires.
module sector_read_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SECTOR_BYTES   = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  rq_req,
    input  logic [31:0] rq0_lba,
    input  logic [31:0] rq1_lba,
    output logic [1:0]  rq_busy,
    output logic [1:0]  rq_done,
    output logic [1:0]  rq_err,
    output logic [1:0]  rq_byte_valid,
    output logic [7:0]  rd_byte,
    output logic        bk_start,
    output logic [31:0] bk_lba,
    output logic        bk_abort,
    input  logic        bk_busy,
    input  logic        bk_done,
    input  logic        bk_err,
    input  logic        bk_byte_valid,
    input  logic [7:0]  bk_byte,
    output logic        ovf_sticky
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_W = 10;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FINISH} state_t;

    state_t           state, state_n;
    logic             gnt, gnt_n;
    logic             last, last_n;
    logic [1:0]       pending, pending_n;
    logic [1:0]       active, active_n;
    logic [1:0]       take, accept;
    logic [31:0]      lba0, lba1;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_eff;
    logic [WD_W-1:0]  wd, wd_n;
    logic             g_pick;
    logic [1:0]       busy_n, done_n, err_n, bv_n;
    logic [7:0]       rd_byte_n;
    logic             start_n, abort_n, ovf_n;
    logic [31:0]      lba_n;

    function automatic logic [1:0] port_mask(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state, grant, counters and next values of the registered outputs
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        last_n    = last;
        active_n  = active;
        lba_n     = bk_lba;
        cnt_n     = cnt;
        cnt_eff   = cnt;
        wd_n      = wd;
        start_n   = 1'b0;
        abort_n   = 1'b0;
        done_n    = 2'b00;
        err_n     = 2'b00;
        bv_n      = 2'b00;
        rd_byte_n = rd_byte;
        take      = 2'b00;
        // Both pending: serve the port that was not served last
        g_pick    = (&pending) ? ~last : pending[1];

        case (state)
            IDLE: begin
                if (|pending) begin
                    gnt_n    = g_pick;
                    take     = port_mask(g_pick);
                    active_n = active | port_mask(g_pick);
                    lba_n    = g_pick ? lba1 : lba0;
                    start_n  = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (bk_byte_valid) begin
                    bv_n      = port_mask(gnt);
                    rd_byte_n = bk_byte;
                    cnt_eff   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    wd_n      = '0;
                end
                cnt_n = cnt_eff;
                // Active is released on entry to FINISH so busy falls with done
                if (bk_done) begin
                    done_n   = port_mask(gnt);
                    err_n    = (bk_err || (32'(cnt_eff) != SECTOR_BYTES)) ? port_mask(gnt) : 2'b00;
                    active_n = active & ~port_mask(gnt);
                    last_n   = gnt;
                    state_n  = FINISH;
                end else if (!bk_byte_valid) begin
                    if (wd == WD_LAST) begin
                        abort_n = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        wd_n = wd + WD_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!bk_busy) begin
                    done_n   = port_mask(gnt);
                    err_n    = port_mask(gnt);
                    active_n = active & ~port_mask(gnt);
                    last_n   = gnt;
                    state_n  = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        accept    = rq_req & ~pending & ~active;
        pending_n = (pending & ~take) | accept;
        ovf_n     = ovf_sticky | (|(rq_req & (pending | active)));
        busy_n    = pending_n | active_n;
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt           <= 1'b0;
            last          <= 1'b1;
            pending       <= 2'b00;
            active        <= 2'b00;
            lba0          <= '0;
            lba1          <= '0;
            cnt           <= '0;
            wd            <= '0;
            rq_busy       <= 2'b00;
            rq_done       <= 2'b00;
            rq_err        <= 2'b00;
            rq_byte_valid <= 2'b00;
            rd_byte       <= '0;
            bk_start      <= 1'b0;
            bk_lba        <= '0;
            bk_abort      <= 1'b0;
            ovf_sticky    <= 1'b0;
        end else begin
            gnt           <= gnt_n;
            last          <= last_n;
            pending       <= pending_n;
            active        <= active_n;
            if (accept[0]) lba0 <= rq0_lba;
            if (accept[1]) lba1 <= rq1_lba;
            cnt           <= cnt_n;
            wd            <= wd_n;
            rq_busy       <= busy_n;
            rq_done       <= done_n;
            rq_err        <= err_n;
            rq_byte_valid <= bv_n;
            rd_byte       <= rd_byte_n;
            bk_start      <= start_n;
            bk_lba        <= lba_n;
            bk_abort      <= abort_n;
            ovf_sticky    <= ovf_n;
        end
    end

endmodule

// File: tb/tb_sector_read_arbiter.sv
// Directed bench for sector_read_arbiter with a small timeout for watchdog cases.
module tb_sector_read_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  rq_req;
    logic [31:0] rq0_lba, rq1_lba;
    logic [1:0]  rq_busy, rq_done, rq_err, rq_byte_valid;
    logic [7:0]  rd_byte;
    logic        bk_start, bk_abort, ovf_sticky;
    logic [31:0] bk_lba;
    logic        bk_busy, bk_done, bk_err, bk_byte_valid;
    logic [7:0]  bk_byte;

    int errors = 0;
    int checks = 0;
    int n0 = 0, n1 = 0, bad = 0, idx = 0;

    sector_read_arbiter #(.TIMEOUT_CYCLES(16), .SECTOR_BYTES(512)) dut (
        .clk(clk), .reset_n(reset_n), .rq_req(rq_req),
        .rq0_lba(rq0_lba), .rq1_lba(rq1_lba),
        .rq_busy(rq_busy), .rq_done(rq_done), .rq_err(rq_err),
        .rq_byte_valid(rq_byte_valid), .rd_byte(rd_byte),
        .bk_start(bk_start), .bk_lba(bk_lba), .bk_abort(bk_abort),
        .bk_busy(bk_busy), .bk_done(bk_done), .bk_err(bk_err),
        .bk_byte_valid(bk_byte_valid), .bk_byte(bk_byte),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counter and stream checker: each transfer restarts at byte 0
    always @(negedge clk) begin
        if (bk_start) idx = 0;
        if (rq_byte_valid[0]) n0++;
        if (rq_byte_valid[1]) n1++;
        if (rq_byte_valid != 2'b00) begin
            if (rd_byte != 8'(idx) || rq_byte_valid == 2'b11) bad++;
            idx++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rq_busy, rq_done, rq_err, rq_byte_valid, rd_byte,
                    bk_start, bk_lba, bk_abort, ovf_sticky});
    endfunction

    // Request from idle port p; returns in the first WAIT cycle
    task automatic issue(input int p, input logic [31:0] lba, input string tag);
        rq_req = (p == 1) ? 2'b10 : 2'b01;
        if (p == 1) rq1_lba = lba; else rq0_lba = lba;
        step();
        rq_req = 2'b00;
        check({tag, "_busy"}, 64'({rq_busy, bk_start}), (p == 1) ? 64'h4 : 64'h2);
        step();
        check({tag, "_start"}, 64'({bk_start, bk_lba}), 64'({1'b1, lba}));
        bk_busy = 1'b1;
        step();
        check({tag, "_start_pulse"}, 64'(bk_start), 64'd0);
    endtask

    task automatic send_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bk_byte_valid = 1'b1;
            bk_byte       = 8'(first + i);
            step();
        end
        bk_byte_valid = 1'b0;
    endtask

    task automatic finish(input logic e);
        bk_done = 1'b1;
        bk_err  = e;
        bk_busy = 1'b0;
        step();
        bk_done = 1'b0;
        bk_err  = 1'b0;
    endtask

    initial begin
        int s0, s1, hits;
        logic early;
        reset_n = 1'b0; rq_req = 2'b00; rq0_lba = '0; rq1_lba = '0;
        bk_busy = 1'b0; bk_done = 1'b0; bk_err = 1'b0;
        bk_byte_valid = 1'b0; bk_byte = '0;
        step(); step();
        check("reset_outs", all_outs(), 64'd0);
        reset_n = 1'b1;
        step();

        // Single full read on port 0
        s0 = n0; s1 = n1;
        issue(0, 32'h0, "t1");
        send_bytes(0, 512);
        check("t1_last_byte", 64'({rq_byte_valid, rd_byte}), 64'h1FF);
        finish(1'b0);
        check("t1_done", 64'({rq_done, rq_err, rq_busy}), 64'h10);
        check("t1_strobes", 64'({n0 - s0, n1 - s1}), 64'({32'd512, 32'd0}));
        check("t1_data", 64'(bad), 64'd0);
        step();

        // Simultaneous requests right after reset: port 0 then port 1
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
        s1 = n1;
        rq_req = 2'b11; rq0_lba = 32'd5; rq1_lba = 32'd9;
        step();
        rq_req = 2'b00;
        check("t2_busy", 64'(rq_busy), 64'h3);
        step();
        check("t2_start0", 64'({bk_start, bk_lba}), 64'({1'b1, 32'd5}));
        bk_busy = 1'b1;
        step();
        send_bytes(0, 512);
        finish(1'b0);
        check("t2_done0", 64'({rq_done, rq_err, rq_busy}), 64'h12);
        step();
        check("t2_busy1", 64'({rq_busy, bk_start}), 64'h4);
        step();
        check("t2_start1", 64'({bk_start, bk_lba, rq_busy}), 64'({1'b1, 32'd9, 2'b10}));
        bk_busy = 1'b1;
        step();
        send_bytes(0, 512);
        finish(1'b0);
        check("t2_done1", 64'({rq_done, rq_err, rq_busy}), 64'h20);
        check("t2_strobes1", 64'(n1 - s1), 64'd512);
        step();

        // Short sector, then re-request in the done cycle, then byte+done together
        issue(1, 32'h1234, "t3");
        send_bytes(0, 511);
        finish(1'b0);
        check("t3_short", 64'({rq_done, rq_err}), 64'ha);
        rq_req = 2'b10; rq1_lba = 32'h55;
        step();
        rq_req = 2'b00;
        check("t3_reaccept", 64'({rq_busy, ovf_sticky}), 64'h4);
        step();
        check("t3_restart", 64'({bk_start, bk_lba}), 64'({1'b1, 32'h55}));
        bk_busy = 1'b1;
        step();
        send_bytes(0, 511);
        bk_byte_valid = 1'b1; bk_byte = 8'hFF; bk_done = 1'b1; bk_busy = 1'b0;
        step();
        bk_byte_valid = 1'b0; bk_done = 1'b0;
        check("t3_byte_done", 64'({rq_byte_valid, rd_byte, rq_done, rq_err}), 64'({2'b10, 8'hFF, 2'b10, 2'b00}));
        check("t3_data", 64'(bad), 64'd0);
        step();

        // Watchdog: stall after byte 3, bytes and done during drain are dropped
        issue(0, 32'h42, "t4");
        send_bytes(0, 3);
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if (bk_abort) early = 1'b1;
            step();
        end
        check("t4_abort_early", 64'(early), 64'd0);
        check("t4_abort", 64'(bk_abort), 64'd1);
        s0 = n0;
        bk_byte_valid = 1'b1; bk_byte = 8'h03;
        step();
        check("t4_abort_pulse", 64'(bk_abort), 64'd0);
        step();
        bk_done = 1'b1;
        step();
        bk_done = 1'b0; bk_byte_valid = 1'b0; bk_busy = 1'b0;
        check("t4_drain_wait", 64'({rq_done, rq_busy}), 64'h1);
        step();
        check("t4_done", 64'({rq_done, rq_err, rq_busy}), 64'h14);
        check("t4_drain_fwd", 64'(n0 - s0), 64'd0);
        step();

        // Duplicate request mid-transfer
        issue(0, 32'h77, "t5");
        send_bytes(0, 100);
        rq_req = 2'b01; rq0_lba = 32'hDEAD;
        step();
        rq_req = 2'b00;
        check("t5_ovf", 64'({ovf_sticky, bk_lba, rq_busy}), 64'({1'b1, 32'h77, 2'b01}));
        send_bytes(100, 412);
        finish(1'b0);
        check("t5_done", 64'({rq_done, rq_err, rq_busy}), 64'h10);
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rq_done != 2'b00 || bk_start) hits++;
        end
        check("t5_single", 64'(hits), 64'd0);

        // Reset during byte 200, then a clean read
        issue(1, 32'hABCD, "t6");
        send_bytes(0, 199);
        bk_byte_valid = 1'b1; bk_byte = 8'(199);
        reset_n = 1'b0;
        #1;
        check("t6_reset_outs", all_outs(), 64'd0);
        step();
        bk_byte_valid = 1'b0; bk_busy = 1'b0;
        reset_n = 1'b1;
        step();
        check("t6_idle", all_outs(), 64'd0);
        s0 = n0;
        issue(0, 32'h3, "t6b");
        send_bytes(0, 512);
        finish(1'b0);
        check("t6_done", 64'({rq_done, rq_err, rq_busy}), 64'h10);
        check("t6_strobes", 64'(n0 - s0), 64'd512);
        check("t6_data", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
